// File: rtl/neuro_mul_pkg.sv
// Shared widths, scheduler state encoding and operand helpers for the
// shared-multiplier scheduler.
package neuro_mul_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // True when the product is trivially zero and the multiplier can be skipped.
  function automatic logic has_zero_operand(input logic [MUL_W-1:0] a,
                                            input logic [MUL_W-1:0] b);
    return (a == {MUL_W{1'b0}}) || (b == {MUL_W{1'b0}});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or above ptr
// (wrapping) wins. The pointer itself is owned by the caller.
module rr_arbiter
  import neuro_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic           found_s;
  logic [IDW-1:0] cand_s;

  // Scan requesters starting at ptr; the first one found keeps the grant.
  always_comb begin
    found_s   = 1'b0;
    grant_idx = {IDW{1'b0}};
    cand_s    = {IDW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_s    = IDW'((int'(ptr) + i) % N_REQ);
      grant_idx = (!found_s && req[cand_s]) ? cand_s : grant_idx;
      found_s   = found_s | req[cand_s];
    end
    grant = found_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : {N_REQ{1'b0}};
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one sequential 32x32 shift-add multiplier among N_REQ requesters.
// One job in flight at a time; the product returns tagged with the owner id.
// A job whose multiplier never signals done is aborted after TIMEOUT_CYC
// WAIT cycles by pulsing the multiplier reset.
module mult_share_sched
  import neuro_mul_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 40,
  parameter int ZERO_BYPASS = 1,
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*MUL_W-1:0] req_a,
  input  logic [N_REQ*MUL_W-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [PROD_W-1:0]      rsp_result,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   mul_start,
  output logic [MUL_W-1:0]       mul_a,
  output logic [MUL_W-1:0]       mul_b,
  output logic                   mul_rst,
  input  logic [PROD_W-1:0]      mul_result,
  input  logic                   mul_done
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_t      state_r, state_n;
  logic [IDW-1:0]    rr_ptr_r, rr_ptr_n;
  logic [MUL_W-1:0]  a_r, a_n, b_r, b_n;
  logic [IDW-1:0]    id_r, id_n;
  logic [TW-1:0]     tmo_r, tmo_n;

  logic [N_REQ-1:0]  rsp_valid_r, rsp_valid_n;
  logic [IDW-1:0]    rsp_id_r, rsp_id_n;
  logic [PROD_W-1:0] rsp_result_r, res_n;
  logic              rsp_err_r, err_n;
  logic              busy_r;
  logic              mul_start_r, start_n;
  logic              abort_r, abort_n;

  logic [N_REQ-1:0]  grant_s;
  logic [IDW-1:0]    grant_idx_s;
  logic [MUL_W-1:0]  sel_a_s, sel_b_s;
  logic [N_REQ-1:0]  req_ready_s;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign sel_a_s = req_a[int'(grant_idx_s)*MUL_W +: MUL_W];
  assign sel_b_s = req_b[int'(grant_idx_s)*MUL_W +: MUL_W];

  // Next-state and per-job bookkeeping; response fields are computed here
  // and registered so they appear exactly during RESP.
  always_comb begin
    state_n     = state_r;
    rr_ptr_n    = rr_ptr_r;
    a_n         = a_r;
    b_n         = b_r;
    id_n        = id_r;
    tmo_n       = tmo_r;
    res_n       = {PROD_W{1'b0}};
    err_n       = 1'b0;
    start_n     = 1'b0;
    abort_n     = 1'b0;
    req_ready_s = {N_REQ{1'b0}};
    case (state_r)
      IDLE: begin
        if (!rst && (grant_s != {N_REQ{1'b0}})) begin
          req_ready_s = grant_s;
          a_n         = sel_a_s;
          b_n         = sel_b_s;
          id_n        = grant_idx_s;
          rr_ptr_n    = (grant_idx_s == IDW'(N_REQ-1)) ? {IDW{1'b0}}
                                                       : grant_idx_s + IDW'(1);
          if ((ZERO_BYPASS != 0) && has_zero_operand(sel_a_s, sel_b_s)) begin
            state_n = RESP;
          end else begin
            state_n = ISSUE;
            start_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        // A stale done from the previous job may still be high; ignore it.
        state_n = WAIT;
        tmo_n   = {TW{1'b0}};
      end
      WAIT: begin
        tmo_n = tmo_r + TW'(1);
        if (mul_done) begin
          res_n   = mul_result;
          state_n = RESP;
        end else if (tmo_r == TW'(TIMEOUT_CYC-1)) begin
          err_n   = 1'b1;
          abort_n = 1'b1;
          state_n = RESP;
        end else begin
          state_n = WAIT;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    rsp_valid_n = (state_n == RESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_n)
                                    : {N_REQ{1'b0}};
    rsp_id_n    = (state_n == RESP) ? id_n : {IDW{1'b0}};
  end

  // State, job registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rr_ptr_r     <= {IDW{1'b0}};
      a_r          <= {MUL_W{1'b0}};
      b_r          <= {MUL_W{1'b0}};
      id_r         <= {IDW{1'b0}};
      tmo_r        <= {TW{1'b0}};
      rsp_valid_r  <= {N_REQ{1'b0}};
      rsp_id_r     <= {IDW{1'b0}};
      rsp_result_r <= {PROD_W{1'b0}};
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      mul_start_r  <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      state_r      <= state_n;
      rr_ptr_r     <= rr_ptr_n;
      a_r          <= a_n;
      b_r          <= b_n;
      id_r         <= id_n;
      tmo_r        <= tmo_n;
      rsp_valid_r  <= rsp_valid_n;
      rsp_id_r     <= rsp_id_n;
      rsp_result_r <= res_n;
      rsp_err_r    <= err_n;
      busy_r       <= (state_n != IDLE);
      mul_start_r  <= start_n;
      abort_r      <= abort_n;
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;
  assign mul_start  = mul_start_r;
  assign mul_a      = a_r;
  assign mul_b      = b_r;
  assign mul_rst    = rst | abort_r;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: behavioural 32-step multiplier (with a stall
// input) plus a reference model of arbitration order, latency and products.
module tb_mult_share_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [3:0]   rsp_valid;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic         rsp_err, busy, mul_start, mul_rst, mul_done;
  logic [31:0]  mul_a, mul_b;
  logic [63:0]  mul_result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ref_ptr   = 0;
  bit stall     = 1'b0;

  always #5 clk = ~clk;

  mult_share_sched #(.N_REQ(4), .TIMEOUT_CYC(40), .ZERO_BYPASS(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  // Sequential multiplier model: edge-qualified start, done 34 cycles after
  // the start cycle, done level held until the next start; stall freezes it.
  logic [63:0] m_res;
  logic        m_done;
  logic        m_start_q;
  logic [31:0] m_a, m_b;
  int          m_steps = 0;
  assign mul_result = m_res;
  assign mul_done   = m_done;

  always @(posedge clk) begin
    m_start_q <= mul_start;
    if (mul_rst) begin
      m_done <= 1'b0; m_steps <= 0; m_res <= 64'h0;
    end else if (mul_start && !m_start_q) begin
      m_a <= mul_a; m_b <= mul_b; m_steps <= 33; m_done <= 1'b0;
    end else if (m_steps != 0 && !stall) begin
      if (m_steps == 1) begin
        m_done <= 1'b1;
        m_res  <= {32'h0, m_a} * {32'h0, m_b};
      end
      m_steps <= m_steps - 1;
    end
  end

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  function automatic int ref_grant(input logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[(ref_ptr + k) % 4]) return (ref_ptr + k) % 4;
    end
    return -1;
  endfunction

  // Drives one job for requester id and observes the following 60 cycles.
  task automatic run_job(input int id, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [3:0] rdy, output logic [3:0] rv,
                         output logic [1:0] rid, output logic [63:0] rres, output logic rerr,
                         output int nrsp, output int nstart, output int nmrst);
    int hs, rc;
    hs = -1; rc = -1; rdy = 4'h0; rv = 4'h0; rid = 2'h0; rres = 64'h0; rerr = 1'b0;
    nrsp = 0; nstart = 0; nmrst = 0;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_valid = oh(id);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (hs < 0 && req_ready != 4'h0) begin hs = c; rdy = req_ready; end
      if (mul_start) nstart++;
      if (mul_rst) nmrst++;
      if (rsp_valid != 4'h0) begin
        nrsp++;
        if (rc < 0) begin rc = c; rv = rsp_valid; rid = rsp_id; rres = rsp_result; rerr = rsp_err; end
      end
      @(posedge clk); #1;
      if (hs >= 0) req_valid = 4'h0;
    end
    req_valid = 4'h0;
    lat = (hs >= 0 && rc >= 0) ? rc - hs : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_a = {4{32'h1234_5678}}; req_b = {4{32'h9}};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++; if (mul_rst !== 1'b1) $display("FAIL reset_mul_rst: got %b expected 1", mul_rst); else pass_cnt++;
      total_cnt++; if (req_ready !== 4'h0) $display("FAIL reset_ready: got %b expected 0000", req_ready); else pass_cnt++;
      total_cnt++; if ({rsp_valid, rsp_id, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b} !== '0)
        $display("FAIL reset_outputs: got rv=%b id=%0d res=%h err=%b busy=%b start=%b a=%h b=%h expected all 0",
                 rsp_valid, rsp_id, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b0; req_valid = 4'h0;
    @(negedge clk);
    total_cnt++; if (mul_rst !== 1'b0) $display("FAIL reset_release_mul_rst: got %b expected 0", mul_rst); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    ref_ptr = 0;
  endtask

  // Continuous traffic checked cycle by cycle against the reference model.
  task automatic test_traffic(input bit all_valid, input int n_jobs);
    logic [3:0]  mask, exp_rdy;
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [63:0] cur_exp;
    int hs_cnt, done_jobs, due, cur_id, g;
    bit pending;
    hs_cnt = 0; done_jobs = 0; due = 0; cur_id = 0; pending = 1'b0; cur_exp = 64'h0;
    for (int c = 0; c < n_jobs*45 + 60 && done_jobs < n_jobs; c++) begin
      mask = (hs_cnt >= n_jobs) ? 4'h0 : (all_valid ? 4'hF : 4'($urandom_range(0, 15)));
      for (int i = 0; i < 4; i++) begin
        ca[i] = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        cb[i] = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
        req_a[i*32 +: 32] = ca[i];
        req_b[i*32 +: 32] = cb[i];
      end
      req_valid = mask;
      @(negedge clk);
      g = -1;
      if (!pending && mask != 4'h0) g = all_valid ? (hs_cnt % 4) : ref_grant(mask);
      exp_rdy = (g >= 0) ? oh(g) : 4'h0;
      total_cnt++; if (req_ready !== exp_rdy) $display("FAIL traffic_ready: cycle %0d got %b expected %b", c, req_ready, exp_rdy); else pass_cnt++;
      if (pending && c == due) begin
        total_cnt++; if (rsp_valid !== oh(cur_id)) $display("FAIL traffic_rsp_valid: got %b expected %b", rsp_valid, oh(cur_id)); else pass_cnt++;
        total_cnt++; if (rsp_id !== cur_id[1:0]) $display("FAIL traffic_rsp_id: got %0d expected %0d", rsp_id, cur_id); else pass_cnt++;
        total_cnt++; if (rsp_result !== cur_exp) $display("FAIL traffic_result: got %h expected %h", rsp_result, cur_exp); else pass_cnt++;
        total_cnt++; if (rsp_err !== 1'b0) $display("FAIL traffic_err: got %b expected 0", rsp_err); else pass_cnt++;
        pending = 1'b0;
        done_jobs++;
      end else begin
        total_cnt++; if (rsp_valid !== 4'h0) $display("FAIL traffic_spurious_rsp: cycle %0d got %b expected 0000", c, rsp_valid); else pass_cnt++;
      end
      if (g >= 0) begin
        pending = 1'b1;
        cur_id  = g;
        cur_exp = {32'h0, ca[g]} * {32'h0, cb[g]};
        due     = c + ((ca[g] == 32'h0 || cb[g] == 32'h0) ? 1 : 36);
        ref_ptr = (g + 1) % 4;
        hs_cnt++;
      end
      @(posedge clk); #1;
    end
    req_valid = 4'h0;
    total_cnt++; if (done_jobs != n_jobs) $display("FAIL traffic_jobs: got %0d expected %0d", done_jobs, n_jobs); else pass_cnt++;
  endtask

  task automatic test_single();
    int lat, nrsp, nst, nmr; logic [3:0] rdy, rv; logic [1:0] rid; logic [63:0] rres; logic rerr;
    run_job(1, 32'd3, 32'd5, lat, rdy, rv, rid, rres, rerr, nrsp, nst, nmr);
    total_cnt++; if (rdy !== 4'b0010) $display("FAIL single_ready: got %b expected 0010", rdy); else pass_cnt++;
    total_cnt++; if (lat != 36) $display("FAIL single_latency: got %0d expected 36", lat); else pass_cnt++;
    total_cnt++; if (rv !== 4'b0010 || rid !== 2'd1) $display("FAIL single_owner: got rv=%b id=%0d expected 0010/1", rv, rid); else pass_cnt++;
    total_cnt++; if (rres !== 64'd15 || rerr !== 1'b0) $display("FAIL single_result: got %h err=%b expected 15 err=0", rres, rerr); else pass_cnt++;
    total_cnt++; if (nrsp != 1 || nst != 1) $display("FAIL single_counts: got rsp=%0d start=%0d expected 1/1", nrsp, nst); else pass_cnt++;
    ref_ptr = 2;
  endtask

  task automatic test_bypass();
    int lat, nrsp, nst, nmr; logic [3:0] rdy, rv; logic [1:0] rid; logic [63:0] rres; logic rerr;
    run_job(2, 32'd0, 32'd123, lat, rdy, rv, rid, rres, rerr, nrsp, nst, nmr);
    total_cnt++; if (lat != 1) $display("FAIL bypass_a0_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (rv !== 4'b0100 || rres !== 64'h0) $display("FAIL bypass_a0_rsp: got rv=%b res=%h expected 0100/0", rv, rres); else pass_cnt++;
    total_cnt++; if (nst != 0) $display("FAIL bypass_a0_start: got %0d starts expected 0", nst); else pass_cnt++;
    run_job(0, $urandom | 32'h1, 32'd0, lat, rdy, rv, rid, rres, rerr, nrsp, nst, nmr);
    total_cnt++; if (lat != 1 || rres !== 64'h0 || nst != 0) $display("FAIL bypass_b0: got lat=%0d res=%h starts=%0d expected 1/0/0", lat, rres, nst); else pass_cnt++;
    ref_ptr = 1;
  endtask

  task automatic test_max_operands();
    int lat, nrsp, nst, nmr; logic [3:0] rdy, rv; logic [1:0] rid; logic [63:0] rres; logic rerr;
    run_job(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy, rv, rid, rres, rerr, nrsp, nst, nmr);
    total_cnt++; if (rres !== 64'hFFFF_FFFE_0000_0001) $display("FAIL max_result: got %h expected fffffffe00000001", rres); else pass_cnt++;
    total_cnt++; if (lat != 36 || rid !== 2'd3) $display("FAIL max_timing: got lat=%0d id=%0d expected 36/3", lat, rid); else pass_cnt++;
    ref_ptr = 0;
  endtask

  task automatic test_timeout();
    int lat, nrsp, nst, nmr; logic [3:0] rdy, rv; logic [1:0] rid; logic [63:0] rres; logic rerr;
    stall = 1'b1;
    run_job(1, $urandom | 32'h1, $urandom | 32'h1, lat, rdy, rv, rid, rres, rerr, nrsp, nst, nmr);
    stall = 1'b0;
    total_cnt++; if (lat != 42) $display("FAIL timeout_latency: got %0d expected 42", lat); else pass_cnt++;
    total_cnt++; if (rerr !== 1'b1 || rres !== 64'h0) $display("FAIL timeout_rsp: got err=%b res=%h expected 1/0", rerr, rres); else pass_cnt++;
    total_cnt++; if (rv !== 4'b0010 || nrsp != 1) $display("FAIL timeout_owner: got rv=%b nrsp=%0d expected 0010/1", rv, nrsp); else pass_cnt++;
    total_cnt++; if (nmr != 1) $display("FAIL timeout_mul_rst: got %0d pulse cycles expected 1", nmr); else pass_cnt++;
    run_job(2, 32'd7, 32'd6, lat, rdy, rv, rid, rres, rerr, nrsp, nst, nmr);
    total_cnt++; if (rres !== 64'd42 || rerr !== 1'b0 || lat != 36) $display("FAIL timeout_recover: got res=%0d err=%b lat=%0d expected 42/0/36", rres, rerr, lat); else pass_cnt++;
    total_cnt++; if (nmr != 0) $display("FAIL timeout_recover_mul_rst: got %0d expected 0", nmr); else pass_cnt++;
    ref_ptr = 3;
  endtask

  task automatic test_reset_mid_job();
    int hs, nrsp;
    hs = -1; nrsp = 0;
    req_a[2*32 +: 32] = $urandom | 32'h1;
    req_b[2*32 +: 32] = $urandom | 32'h1;
    req_valid = 4'b0100;
    for (int c = 0; c < 5 && hs < 0; c++) begin
      @(negedge clk);
      if (req_ready != 4'h0) hs = c;
      @(posedge clk); #1;
    end
    req_valid = 4'h0;
    total_cnt++; if (hs < 0) $display("FAIL midrst_handshake: got none expected one within 5 cycles"); else pass_cnt++;
    repeat (12) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (mul_rst !== 1'b1) $display("FAIL midrst_mul_rst: got %b expected 1", mul_rst); else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++; if ({rsp_valid, rsp_id, rsp_result, rsp_err, busy, mul_start, mul_a, mul_b} !== '0)
      $display("FAIL midrst_outputs: got rv=%b busy=%b start=%b a=%h b=%h expected all 0", rsp_valid, busy, mul_start, mul_a, mul_b);
    else pass_cnt++;
    total_cnt++; if (mul_rst !== 1'b1) $display("FAIL midrst_mul_rst_hold: got %b expected 1", mul_rst); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rsp_valid != 4'h0) nrsp++;
      @(posedge clk); #1;
    end
    total_cnt++; if (nrsp != 0) $display("FAIL midrst_dropped_rsp: got %0d responses expected 0", nrsp); else pass_cnt++;
    req_valid = 4'hF;
    @(negedge clk);
    total_cnt++; if (req_ready !== 4'b0001) $display("FAIL midrst_rr_ptr: got %b expected 0001", req_ready); else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 4'h0;
    ref_ptr = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 4'h0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    test_reset();
    test_traffic(1'b1, 5);
    test_single();
    test_bypass();
    test_max_operands();
    test_timeout();
    test_traffic(1'b0, 12);
    test_reset_mid_job();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
